// File: rtl/tilelink_ul_arbiter.sv
// 2:1 TL-UL arbiter: round-robin channel A into a registered output stage, channel D routed back by tag bit,
// per-master outstanding counters throttle each master to MAX_OUTSTANDING in-flight requests.
module tilelink_ul_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MASK_WIDTH      = DATA_WIDTH/8,
   parameter int SIZE_WIDTH      = 3,
   parameter int SRC_WIDTH       = 2,
   parameter int SINK_WIDTH      = 1,
   parameter int OPCODE_WIDTH    = 3,
   parameter int PARAM_WIDTH     = 3,
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_WIDTH       = 3
) (
   input  logic                    clk_in,
   input  logic                    reset_in_n,
   // master 0 channel A
   input  logic                    m0_a_valid,
   output logic                    m0_a_ready,
   input  logic [OPCODE_WIDTH-1:0] m0_a_opcode,
   input  logic [PARAM_WIDTH-1:0]  m0_a_param,
   input  logic [SIZE_WIDTH-1:0]   m0_a_size,
   input  logic [SRC_WIDTH-1:0]    m0_a_source,
   input  logic [ADDR_WIDTH-1:0]   m0_a_address,
   input  logic [MASK_WIDTH-1:0]   m0_a_mask,
   input  logic [DATA_WIDTH-1:0]   m0_a_data,
   // master 1 channel A
   input  logic                    m1_a_valid,
   output logic                    m1_a_ready,
   input  logic [OPCODE_WIDTH-1:0] m1_a_opcode,
   input  logic [PARAM_WIDTH-1:0]  m1_a_param,
   input  logic [SIZE_WIDTH-1:0]   m1_a_size,
   input  logic [SRC_WIDTH-1:0]    m1_a_source,
   input  logic [ADDR_WIDTH-1:0]   m1_a_address,
   input  logic [MASK_WIDTH-1:0]   m1_a_mask,
   input  logic [DATA_WIDTH-1:0]   m1_a_data,
   // downstream channel A
   output logic                    s_a_valid,
   input  logic                    s_a_ready,
   output logic [OPCODE_WIDTH-1:0] s_a_opcode,
   output logic [PARAM_WIDTH-1:0]  s_a_param,
   output logic [SIZE_WIDTH-1:0]   s_a_size,
   output logic [SRC_WIDTH:0]      s_a_source,
   output logic [ADDR_WIDTH-1:0]   s_a_address,
   output logic [MASK_WIDTH-1:0]   s_a_mask,
   output logic [DATA_WIDTH-1:0]   s_a_data,
   // downstream channel D
   input  logic                    s_d_valid,
   output logic                    s_d_ready,
   input  logic [OPCODE_WIDTH-1:0] s_d_opcode,
   input  logic [PARAM_WIDTH-1:0]  s_d_param,
   input  logic [SIZE_WIDTH-1:0]   s_d_size,
   input  logic [SRC_WIDTH:0]      s_d_source,
   input  logic [SINK_WIDTH-1:0]   s_d_sink,
   input  logic [DATA_WIDTH-1:0]   s_d_data,
   input  logic                    s_d_error,
   // master 0 channel D
   output logic                    m0_d_valid,
   input  logic                    m0_d_ready,
   output logic [OPCODE_WIDTH-1:0] m0_d_opcode,
   output logic [PARAM_WIDTH-1:0]  m0_d_param,
   output logic [SIZE_WIDTH-1:0]   m0_d_size,
   output logic [SRC_WIDTH-1:0]    m0_d_source,
   output logic [SINK_WIDTH-1:0]   m0_d_sink,
   output logic [DATA_WIDTH-1:0]   m0_d_data,
   output logic                    m0_d_error,
   // master 1 channel D
   output logic                    m1_d_valid,
   input  logic                    m1_d_ready,
   output logic [OPCODE_WIDTH-1:0] m1_d_opcode,
   output logic [PARAM_WIDTH-1:0]  m1_d_param,
   output logic [SIZE_WIDTH-1:0]   m1_d_size,
   output logic [SRC_WIDTH-1:0]    m1_d_source,
   output logic [SINK_WIDTH-1:0]   m1_d_sink,
   output logic [DATA_WIDTH-1:0]   m1_d_data,
   output logic                    m1_d_error,
   // status
   output logic [CNT_WIDTH-1:0]    m0_outstanding,
   output logic [CNT_WIDTH-1:0]    m1_outstanding,
   output logic                    err_unexpected_d
);

   logic rr_ptr;
   logic elig0, elig1, grant0, grant1, load_ok;
   logic acc0, acc1, d_idx, dhs0, dhs1, dec0, dec1;

   // channel A arbitration
   assign elig0   = m0_a_valid && (m0_outstanding < CNT_WIDTH'(MAX_OUTSTANDING));
   assign elig1   = m1_a_valid && (m1_outstanding < CNT_WIDTH'(MAX_OUTSTANDING));
   assign load_ok = !s_a_valid || s_a_ready;
   assign grant0  = elig0 && (!elig1 || !rr_ptr);
   assign grant1  = elig1 && (!elig0 ||  rr_ptr);

   assign m0_a_ready = reset_in_n && load_ok && grant0;
   assign m1_a_ready = reset_in_n && load_ok && grant1;
   assign acc0 = m0_a_valid && m0_a_ready;
   assign acc1 = m1_a_valid && m1_a_ready;

   always_ff @(posedge clk_in or negedge reset_in_n) begin
      if (!reset_in_n) begin
         s_a_valid   <= 1'b0;
         s_a_opcode  <= '0;
         s_a_param   <= '0;
         s_a_size    <= '0;
         s_a_source  <= '0;
         s_a_address <= '0;
         s_a_mask    <= '0;
         s_a_data    <= '0;
         rr_ptr      <= 1'b0;
      end else if (acc0) begin
         s_a_valid   <= 1'b1;
         s_a_opcode  <= m0_a_opcode;
         s_a_param   <= m0_a_param;
         s_a_size    <= m0_a_size;
         s_a_source  <= {1'b0, m0_a_source};
         s_a_address <= m0_a_address;
         s_a_mask    <= m0_a_mask;
         s_a_data    <= m0_a_data;
         rr_ptr      <= 1'b1;
      end else if (acc1) begin
         s_a_valid   <= 1'b1;
         s_a_opcode  <= m1_a_opcode;
         s_a_param   <= m1_a_param;
         s_a_size    <= m1_a_size;
         s_a_source  <= {1'b1, m1_a_source};
         s_a_address <= m1_a_address;
         s_a_mask    <= m1_a_mask;
         s_a_data    <= m1_a_data;
         rr_ptr      <= 1'b0;
      end else if (s_a_ready) begin
         s_a_valid   <= 1'b0;
      end
   end

   // channel D routing by the tag bit; payload broadcast
   assign d_idx      = s_d_source[SRC_WIDTH];
   assign m0_d_valid = s_d_valid && !d_idx;
   assign m1_d_valid = s_d_valid &&  d_idx;
   assign s_d_ready  = d_idx ? m1_d_ready : m0_d_ready;

   assign m0_d_opcode = s_d_opcode;
   assign m0_d_param  = s_d_param;
   assign m0_d_size   = s_d_size;
   assign m0_d_source = s_d_source[SRC_WIDTH-1:0];
   assign m0_d_sink   = s_d_sink;
   assign m0_d_data   = s_d_data;
   assign m0_d_error  = s_d_error;
   assign m1_d_opcode = s_d_opcode;
   assign m1_d_param  = s_d_param;
   assign m1_d_size   = s_d_size;
   assign m1_d_source = s_d_source[SRC_WIDTH-1:0];
   assign m1_d_sink   = s_d_sink;
   assign m1_d_data   = s_d_data;
   assign m1_d_error  = s_d_error;

   // a response against an empty counter is flagged and never decrements
   assign dhs0 = m0_d_valid && m0_d_ready;
   assign dhs1 = m1_d_valid && m1_d_ready;
   assign dec0 = dhs0 && (m0_outstanding != '0);
   assign dec1 = dhs1 && (m1_outstanding != '0);

   always_ff @(posedge clk_in or negedge reset_in_n) begin
      if (!reset_in_n) begin
         m0_outstanding   <= '0;
         m1_outstanding   <= '0;
         err_unexpected_d <= 1'b0;
      end else begin
         if (acc0 && !dec0)      m0_outstanding <= m0_outstanding + CNT_WIDTH'(1);
         else if (!acc0 && dec0) m0_outstanding <= m0_outstanding - CNT_WIDTH'(1);
         if (acc1 && !dec1)      m1_outstanding <= m1_outstanding + CNT_WIDTH'(1);
         else if (!acc1 && dec1) m1_outstanding <= m1_outstanding - CNT_WIDTH'(1);
         if ((dhs0 && !dec0) || (dhs1 && !dec1)) err_unexpected_d <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tilelink_ul_arbiter.sv
// Directed bench for tilelink_ul_arbiter: grant order, backpressure, throttling, D routing, error and reset.
module tb_tilelink_ul_arbiter;

   logic        clk_in = 1'b0;
   logic        reset_in_n;
   logic        m0_a_valid, m0_a_ready, m1_a_valid, m1_a_ready;
   logic [2:0]  m0_a_opcode, m0_a_param, m0_a_size, m1_a_opcode, m1_a_param, m1_a_size;
   logic [1:0]  m0_a_source, m1_a_source;
   logic [31:0] m0_a_address, m0_a_data, m1_a_address, m1_a_data;
   logic [3:0]  m0_a_mask, m1_a_mask;
   logic        s_a_valid, s_a_ready;
   logic [2:0]  s_a_opcode, s_a_param, s_a_size, s_a_source;
   logic [31:0] s_a_address, s_a_data;
   logic [3:0]  s_a_mask;
   logic        s_d_valid, s_d_ready, s_d_error;
   logic [2:0]  s_d_opcode, s_d_param, s_d_size, s_d_source;
   logic [0:0]  s_d_sink;
   logic [31:0] s_d_data;
   logic        m0_d_valid, m0_d_ready, m0_d_error, m1_d_valid, m1_d_ready, m1_d_error;
   logic [2:0]  m0_d_opcode, m0_d_param, m0_d_size, m1_d_opcode, m1_d_param, m1_d_size;
   logic [1:0]  m0_d_source, m1_d_source;
   logic [0:0]  m0_d_sink, m1_d_sink;
   logic [31:0] m0_d_data, m1_d_data;
   logic [2:0]  m0_outstanding, m1_outstanding;
   logic        err_unexpected_d;

   int total = 0;
   int bad   = 0;

   tilelink_ul_arbiter dut (
      .clk_in(clk_in), .reset_in_n(reset_in_n),
      .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
      .m0_a_param(m0_a_param), .m0_a_size(m0_a_size), .m0_a_source(m0_a_source),
      .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
      .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
      .m1_a_param(m1_a_param), .m1_a_size(m1_a_size), .m1_a_source(m1_a_source),
      .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
      .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
      .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
      .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
      .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
      .s_d_param(s_d_param), .s_d_size(s_d_size), .s_d_source(s_d_source),
      .s_d_sink(s_d_sink), .s_d_data(s_d_data), .s_d_error(s_d_error),
      .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_opcode(m0_d_opcode),
      .m0_d_param(m0_d_param), .m0_d_size(m0_d_size), .m0_d_source(m0_d_source),
      .m0_d_sink(m0_d_sink), .m0_d_data(m0_d_data), .m0_d_error(m0_d_error),
      .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_opcode(m1_d_opcode),
      .m1_d_param(m1_d_param), .m1_d_size(m1_d_size), .m1_d_source(m1_d_source),
      .m1_d_sink(m1_d_sink), .m1_d_data(m1_d_data), .m1_d_error(m1_d_error),
      .m0_outstanding(m0_outstanding), .m1_outstanding(m1_outstanding),
      .err_unexpected_d(err_unexpected_d)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic mid();
      @(negedge clk_in);
   endtask

   task automatic clear_inputs();
      m0_a_valid = 0; m0_a_opcode = 0; m0_a_param = 0; m0_a_size = 0; m0_a_source = 0;
      m0_a_address = 0; m0_a_mask = 0; m0_a_data = 0;
      m1_a_valid = 0; m1_a_opcode = 0; m1_a_param = 0; m1_a_size = 0; m1_a_source = 0;
      m1_a_address = 0; m1_a_mask = 0; m1_a_data = 0;
      s_a_ready = 0; s_d_valid = 0; s_d_opcode = 0; s_d_param = 0; s_d_size = 0;
      s_d_source = 0; s_d_sink = 0; s_d_data = 0; s_d_error = 0;
      m0_d_ready = 0; m1_d_ready = 0;
   endtask

   task automatic req0(input logic [1:0] src, input logic [31:0] addr);
      m0_a_valid = 1; m0_a_opcode = 3'd4; m0_a_size = 3'd2; m0_a_source = src;
      m0_a_address = addr; m0_a_mask = 4'hF;
   endtask

   task automatic req1(input logic [1:0] src, input logic [31:0] addr);
      m1_a_valid = 1; m1_a_opcode = 3'd4; m1_a_size = 3'd2; m1_a_source = src;
      m1_a_address = addr; m1_a_mask = 4'hF;
   endtask

   task automatic do_reset();
      reset_in_n = 0;
      clear_inputs();
      mid();
      reset_in_n = 1;
      step();
   endtask

   initial begin
      logic exp_msb [4];
      exp_msb = '{1'b0, 1'b1, 1'b0, 1'b1};

      // reset state, with a request pending to show ready held low
      reset_in_n = 0;
      clear_inputs();
      m0_a_valid = 1;
      #2;
      chk("rst_s_a_valid", s_a_valid, 0);
      chk("rst_s_a_address", s_a_address, 0);
      chk("rst_m0_out", m0_outstanding, 0);
      chk("rst_m1_out", m1_outstanding, 0);
      chk("rst_err", err_unexpected_d, 0);
      chk("rst_m0_a_ready", m0_a_ready, 0);
      m0_a_valid = 0;
      mid();
      reset_in_n = 1;
      step();

      // single request from m0
      req0(2'd1, 32'h1000);
      s_a_ready = 1;
      mid();
      chk("single_m0_ready", m0_a_ready, 1);
      chk("single_m1_ready", m1_a_ready, 0);
      step();
      m0_a_valid = 0;
      chk("single_s_a_valid", s_a_valid, 1);
      chk("single_s_a_source", s_a_source, 3'b001);
      chk("single_s_a_address", s_a_address, 32'h1000);
      chk("single_s_a_opcode", s_a_opcode, 3'd4);
      chk("single_m0_out", m0_outstanding, 1);
      step();
      chk("drain_s_a_valid", s_a_valid, 0);

      // single request from m1 leaves the pointer on m0
      req1(2'd2, 32'h2000);
      mid();
      chk("m1single_ready", m1_a_ready, 1);
      chk("m1single_m0_ready", m0_a_ready, 0);
      step();
      m1_a_valid = 0;
      chk("m1single_source", s_a_source, 3'b110);
      chk("m1single_out", m1_outstanding, 1);

      // contention: alternate grants
      req0(2'd0, 32'h3000);
      req1(2'd3, 32'h4000);
      for (int i = 0; i < 4; i++) begin
         mid();
         chk("cont_m0_ready", m0_a_ready, !exp_msb[i]);
         chk("cont_m1_ready", m1_a_ready, exp_msb[i]);
         step();
         chk("cont_src_msb", s_a_source[2], exp_msb[i]);
      end
      m0_a_valid = 0;
      m1_a_valid = 0;
      chk("cont_m0_out", m0_outstanding, 3);
      chk("cont_m1_out", m1_outstanding, 3);

      // backpressure
      do_reset();
      req0(2'd2, 32'h5000);
      req1(2'd1, 32'h6000);
      s_a_ready = 0;
      mid();
      chk("bp_first_m0_ready", m0_a_ready, 1);
      step();
      m0_a_valid = 0;
      chk("bp_s_a_valid", s_a_valid, 1);
      chk("bp_s_a_address", s_a_address, 32'h5000);
      for (int i = 0; i < 3; i++) begin
         mid();
         chk("bp_hold_m0_ready", m0_a_ready, 0);
         chk("bp_hold_m1_ready", m1_a_ready, 0);
         chk("bp_hold_addr", s_a_address, 32'h5000);
         chk("bp_hold_valid", s_a_valid, 1);
         step();
      end
      chk("bp_hold_src", s_a_source, 3'b010);
      s_a_ready = 1;
      mid();
      chk("bp_release_m1_ready", m1_a_ready, 1);
      step();
      m1_a_valid = 0;
      chk("bp_next_addr", s_a_address, 32'h6000);
      chk("bp_next_src", s_a_source, 3'b101);

      // throttle m1 at the in-flight limit
      do_reset();
      req1(2'd0, 32'h7000);
      s_a_ready = 1;
      for (int i = 0; i < 4; i++) begin
         mid();
         chk("thr_m1_ready", m1_a_ready, 1);
         step();
      end
      chk("thr_m1_out_full", m1_outstanding, 4);
      req0(2'd3, 32'h8000);
      mid();
      chk("thr_m1_blocked", m1_a_ready, 0);
      chk("thr_m0_proceeds", m0_a_ready, 1);
      step();
      m0_a_valid = 0;
      chk("thr_m0_src", s_a_source, 3'b011);
      s_d_valid = 1; s_d_source = 3'b100; m1_d_ready = 1;
      mid();
      chk("thr_d_m1_valid", m1_d_valid, 1);
      chk("thr_d_m0_valid", m0_d_valid, 0);
      chk("thr_d_ready", s_d_ready, 1);
      chk("thr_still_blocked", m1_a_ready, 0);
      step();
      s_d_valid = 0; m1_d_ready = 0;
      chk("thr_m1_out_dec", m1_outstanding, 3);
      mid();
      chk("thr_m1_unblocked", m1_a_ready, 1);
      step();
      m1_a_valid = 0;
      chk("thr_m1_src_msb", s_a_source[2], 1);
      chk("thr_m1_out_back", m1_outstanding, 4);

      // routing with a concurrent m0 accept
      req0(2'd0, 32'h9000);
      s_d_valid = 1; s_d_source = 3'b010; s_d_data = 32'hDEADBEEF; m0_d_ready = 1;
      mid();
      chk("rt_m0_d_valid", m0_d_valid, 1);
      chk("rt_m1_d_valid", m1_d_valid, 0);
      chk("rt_m0_d_source", m0_d_source, 2);
      chk("rt_m0_d_data", m0_d_data, 32'hDEADBEEF);
      chk("rt_m1_d_data", m1_d_data, 32'hDEADBEEF);
      chk("rt_s_d_ready", s_d_ready, 1);
      chk("rt_m0_a_ready", m0_a_ready, 1);
      step();
      m0_a_valid = 0;
      chk("rt_m0_out_same", m0_outstanding, 1);
      m0_d_ready = 0; m1_d_ready = 1;
      mid();
      chk("rt_s_d_ready_follow", s_d_ready, 0);
      step();
      s_d_valid = 0; m1_d_ready = 0;
      chk("rt_m0_out_nohs", m0_outstanding, 1);

      // unexpected response then mid-burst reset
      do_reset();
      s_d_valid = 1; s_d_source = 3'b100; m1_d_ready = 1;
      step();
      s_d_valid = 0; m1_d_ready = 0;
      chk("err_set", err_unexpected_d, 1);
      chk("err_m1_out", m1_outstanding, 0);
      step();
      chk("err_sticky", err_unexpected_d, 1);
      req0(2'd1, 32'hA000);
      req1(2'd2, 32'hB000);
      s_a_ready = 1;
      step();
      step();
      chk("burst_s_a_valid", s_a_valid, 1);
      chk("burst_m0_out", m0_outstanding, 1);
      chk("burst_m1_out", m1_outstanding, 1);
      #2;
      reset_in_n = 0;
      #1;
      chk("arst_s_a_valid", s_a_valid, 0);
      chk("arst_s_a_address", s_a_address, 0);
      chk("arst_m0_out", m0_outstanding, 0);
      chk("arst_m1_out", m1_outstanding, 0);
      chk("arst_err", err_unexpected_d, 0);
      chk("arst_m0_ready", m0_a_ready, 0);
      chk("arst_m1_ready", m1_a_ready, 0);
      clear_inputs();
      mid();
      reset_in_n = 1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tilelink_ul_arbiter.md
Name: tilelink_ul_arbiter

Overview:
- 2:1 TL-UL arbiter that shares one downstream TL-UL slave port, typically the 100 MHz side of the CDC adapter, between two upstream masters.
- Channel A: round-robin arbitration into a registered output stage. The downstream source is tagged as {master_index, source}.
- Channel D: responses are routed back by the tag bit.
- Per-master outstanding counters throttle each master to MAX_OUTSTANDING in-flight requests.

Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- MASK_WIDTH, DATA_WIDTH/8, byte mask width
- SIZE_WIDTH, 3, size field width
- SRC_WIDTH, 2, upstream source width (downstream source is SRC_WIDTH+1)
- SINK_WIDTH, 1, sink width
- OPCODE_WIDTH, 3, opcode width
- PARAM_WIDTH, 3, param width
- MAX_OUTSTANDING, 4, in-flight limit per master (1..2^SRC_WIDTH)
- CNT_WIDTH, 3, counter width; must hold MAX_OUTSTANDING

Ports:
- clk_in  input  1  single clock
- reset_in_n  input  1  asynchronous active-low reset
- mN_a_valid  input  1  master N A valid (N = 0, 1; same for every mN_ line)
- mN_a_ready  output  1  master N A ready
- mN_a_opcode/param/size/source/address/mask/data  input  field widths  master N A payload
- s_a_valid  output  1  downstream A valid (registered)
- s_a_ready  input  1  downstream A ready
- s_a_opcode/param/size/address/mask/data  output  field widths  downstream A payload (registered)
- s_a_source  output  SRC_WIDTH+1  {grant index, master source}
- s_d_valid  input  1  downstream D valid
- s_d_ready  output  1  downstream D ready
- s_d_opcode/param/size/sink/data/error  input  field widths  D payload
- s_d_source  input  SRC_WIDTH+1  tagged source
- mN_d_valid  output  1  master N D valid
- mN_d_ready  input  1  master N D ready
- mN_d_opcode/param/size/sink/data/error  output  field widths  D payload to master N
- mN_d_source  output  SRC_WIDTH  s_d_source[SRC_WIDTH-1:0]
- mN_outstanding  output  CNT_WIDTH  in-flight count for master N
- err_unexpected_d  output  1  sticky: D arrived for a master with count 0

Behaviour:
- Reset (async, reset_in_n = 0):
  - s_a_valid = 0, s_a payload = 0.
  - rr_ptr = 0 (master 0 has priority first).
  - Both counters = 0; err_unexpected_d = 0.
  - mN_a_ready = 0 while in reset.
- Eligibility:
  - elig_N = mN_a_valid && (mN_outstanding < MAX_OUTSTANDING).
  - load_ok = !s_a_valid || s_a_ready.
- Grant (combinational):
  - If both are eligible, the rr_ptr master wins. Otherwise the single eligible master wins.
  - mN_a_ready = load_ok && granted(N). The other master sees ready = 0.
- Accept:
  - On mN_a_valid && mN_a_ready, the output register loads master N's payload with s_a_source = {N, mN_a_source}, and s_a_valid = 1 next cycle. Latency is 1 cycle.
  - rr_ptr <= ~N on every accept.
  - With back-to-back acceptance and s_a_ready held 1, throughput is 1 request per cycle.
- Hold: while s_a_valid && !s_a_ready, the output register and its payload stay stable; both mN_a_ready = 0.
- Drain: s_a_ready && !load → s_a_valid <= 0.
- D routing:
  - Combinational. idx = s_d_source[SRC_WIDTH].
  - m{idx}_d_valid = s_d_valid and the other master's valid = 0.
  - s_d_ready = m{idx}_d_ready.
  - The payload is broadcast to both masters.
- Counters:
  - +1 on A accept for N; -1 on a D handshake routed to N.
  - Same-cycle +1 and -1 on the same master: count unchanged.
  - D handshake with count 0: count stays 0 and err_unexpected_d <= 1 (sticky until reset).
  - A count at MAX_OUTSTANDING blocks that master only; the other master proceeds.
- Mid-operation reset: all state clears immediately, and any in-flight A in the output register is dropped.

Test Plan:
- Single request: m0 Get addr 0x1000, source 1, s_a_ready = 1 → m0_a_ready = 1 in cycle 0; s_a_valid = 1 in cycle 1 with s_a_source = 3'b001; m0_outstanding = 1.
- Contention: both valid for 4 cycles, s_a_ready = 1 → grants in order m0, m1, m0, m1; s_a_source MSBs 0, 1, 0, 1.
- Backpressure: s_a_ready = 0 for 3 cycles with s_a_valid = 1 → payload stable and both mN_a_ready = 0; on release, the next grant goes the cycle after.
- Throttle: m1 issues 4 requests with no D → the 5th is stalled (m1_a_ready = 0) while m0 is still accepted; a D with s_d_source = 3'b1xx → m1_outstanding = 3 and m1 is accepted again.
- Routing plus same-cycle event: D with source 3'b010 and data 0xDEADBEEF, concurrent with an m0 accept → m0_d_valid = 1, m0_d_source = 2, m1_d_valid = 0, m0_outstanding unchanged.
- Error and reset: D to m1 with count 0 → err_unexpected_d = 1 and stays 1; assert reset_in_n = 0 mid-burst → s_a_valid, counters and err clear asynchronously.
